// File: rtl/reload_counter_pkg.sv
// -----------------------------------------------------------------------------
// reload_counter_pkg
//
// Shared types for the reload_counter_gen counter family.
//   cnt_mode_e  : behaviour when the count reaches its terminal value
//                 (encodings match the 2-bit mode_i port of the top).
//   cnt_state_e : top-level control state (RUN counts, DONE is the parked
//                 state of a finished one-shot).
// -----------------------------------------------------------------------------
package reload_counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,  // up: restart at 0, down: restart at limit
    CNT_SAT     = 2'b01,  // hold at the terminal value
    CNT_RELOAD  = 2'b10,  // restart from the last loaded value
    CNT_ONESHOT = 2'b11   // hold and park in ST_DONE
  } cnt_mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cnt_state_e;

endpackage : reload_counter_pkg

// File: rtl/reload_counter_gen_next_val.sv
// -----------------------------------------------------------------------------
// counter_next_val
//
// Purely combinational step logic for reload_counter_gen. Given the current
// count it reports whether the count is terminal and what the count becomes
// if an enabled step is taken on this edge.
//
// Ports:
//   count      in   WIDTH  current count
//   up         in   1      1 = count up, 0 = count down
//   mode       in   2      terminal mode (cnt_mode_e encoding)
//   limit      in   WIDTH  up-count terminal value / down-count wrap target
//   reload_val in   WIDTH  last loaded value, used by RELOAD mode
//   next_count out  WIDTH  count after an enabled step
//   terminal   out  1      count is at its terminal value for this direction
// -----------------------------------------------------------------------------
module counter_next_val
  import reload_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] reload_val,
  output logic [WIDTH-1:0] next_count,
  output logic             terminal
);

  cnt_mode_e mode_e;
  assign mode_e = cnt_mode_e'(mode);

  // Unsigned >= so that a count loaded above the limit is treated as terminal
  // instead of running on until it overflows.
  assign terminal = up ? (count >= limit) : (count == '0);

  always_comb begin
    // NOTE: next_count gets a default before any branch; a path that left it
    // unassigned would infer a latch instead of combinational logic.
    next_count = count;
    if (!terminal) begin
      // The terminal check keeps the up step below 2^WIDTH-1 + 1, so neither
      // direction relies on modulo wrap-around here.
      next_count = up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
    end else begin
      case (mode_e)
        CNT_WRAP:    next_count = up ? '0 : limit;
        CNT_SAT:     next_count = count;
        CNT_RELOAD:  next_count = reload_val;
        CNT_ONESHOT: next_count = count;
        default:     next_count = count;
      endcase
    end
  end

endmodule : counter_next_val

// File: rtl/reload_counter_gen.sv
// -----------------------------------------------------------------------------
// reload_counter_gen
//
// Parametrised up/down counter with runtime terminal limit, four terminal
// modes (wrap, saturate, reload-from-last-load, one-shot), count enable and a
// registered terminal-count pulse. Loads are accepted on any cycle.
//
// Edge priority: reset > load_i > enabled step > hold.
//
// Optional feature (macro RELOAD_COUNTER_STICKY_OVF_EN): sticky overflow flag
// ovf_o, set on every terminal action, cleared by ovf_clr_i (set wins), reset
// clears it, load_i leaves it alone.
//
// Parameters:
//   WIDTH    counter / load value / limit width
//   RST_VAL  count and reload value after reset
//
// Ports:
//   clk         in   1      clock, rising edge
//   reset       in   1      synchronous, active-high reset
//   en_i        in   1      count enable
//   load_i      in   1      load strobe
//   load_val_i  in   WIDTH  load value, also captured as reload value
//   up_i        in   1      1 = up, 0 = down
//   mode_i      in   2      00 WRAP, 01 SAT, 10 RELOAD, 11 ONESHOT
//   limit_i     in   WIDTH  up terminal value / down wrap target
//   count_o     out  WIDTH  registered count
//   tc_o        out  1      terminal action taken on the previous edge
//   done_o      out  1      one-shot has finished (state DONE)
//   ovf_clr_i   in   1      (optional) clear sticky overflow
//   ovf_o       out  1      (optional) sticky overflow flag
// -----------------------------------------------------------------------------
module reload_counter_gen
  import reload_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             done_o
`ifdef RELOAD_COUNTER_STICKY_OVF_EN
  ,
  input  logic             ovf_clr_i,
  output logic             ovf_o
`endif
);

  cnt_mode_e        mode_e;
  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step_val;
  logic             terminal;
  logic             term_act;

  assign mode_e = cnt_mode_e'(mode_i);

  counter_next_val #(
    .WIDTH (WIDTH)
  ) u_next_val (
    .count      (count_q),
    .up         (up_i),
    .mode       (mode_i),
    .limit      (limit_i),
    .reload_val (reload_q),
    .next_count (step_val),
    .terminal   (terminal)
  );

  // Next-state / next-count decision.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    term_act = 1'b0;

    if (load_i) begin
      // Load overrides enable, mode and state; it also re-arms a finished
      // one-shot.
      count_d  = load_val_i;
      reload_d = load_val_i;
      state_d  = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (en_i) begin
            count_d = step_val;
            if (terminal) begin
              term_act = 1'b1;
              tc_d     = 1'b1;
              if (mode_e == CNT_ONESHOT) state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Leaving DONE because the mode changed costs one edge: no step
          // is taken here, counting resumes on the following edge.
          if (mode_e != CNT_ONESHOT) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= ST_RUN;
      count_q  <= RST_VAL;
      reload_q <= RST_VAL;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign done_o  = (state_q == ST_DONE);

`ifdef RELOAD_COUNTER_STICKY_OVF_EN
  logic ovf_q;

  // Set has priority over clear so a terminal action is never lost.
  always_ff @(posedge clk) begin
    if (reset)          ovf_q <= 1'b0;
    else if (term_act)  ovf_q <= 1'b1;
    else if (ovf_clr_i) ovf_q <= 1'b0;
  end

  assign ovf_o = ovf_q;
`else
  // Without the sticky flag the terminal-action strobe has no consumer.
  logic unused_term_act;
  assign unused_term_act = term_act;
`endif

endmodule : reload_counter_gen

// File: doc/reload_counter_gen.md
Name: reload_counter_gen

Overview:
Parametrised up/down counter: the next generation of the team's 4-bit load counter. It adds a runtime terminal limit, four terminal-count modes (wrap, saturate, reload-from-last-load, one-shot), an enable, and a registered terminal-count pulse. Loading is accepted on any cycle, not only at the maximum count. It serves as the general timer/sequencer primitive for later blocks.

Parameters:
WIDTH, 4, counter, load value and limit width in bits.
RST_VAL, 0, value of count_o and of the reload register after reset.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
en_i  input  1  count enable; step taken only when high
load_i  input  1  load strobe; highest priority after reset
load_val_i  input  WIDTH  value to load; also captured as reload value
up_i  input  1  1 = count up, 0 = count down
mode_i  input  2  terminal mode: 00 WRAP, 01 SAT, 10 RELOAD, 11 ONESHOT
limit_i  input  WIDTH  up-count terminal value; down-count wrap target
count_o  output  WIDTH  current count (registered)
tc_o  output  1  registered pulse: a terminal action was taken on the previous edge
done_o  output  1  high while in DONE state (ONESHOT only)

Behaviour:
- One clock, clk. Reset is synchronous, active-high, on port reset. Reset state: count_o=RST_VAL, reload_q=RST_VAL, state=RUN, tc_o=0, done_o=0.
- Edge priority: reset > load_i > en_i step > hold.
- load_i=1: count<=load_val_i, reload_q<=load_val_i, state<=RUN, tc_o<=0. Applies regardless of en_i, mode or state.
- Terminal condition: up_i=1 and count>=limit_i (unsigned; a loaded value above the limit is terminal), or up_i=0 and count==0.
- Non-terminal step (en_i=1, state RUN): count+1 if up, count-1 if down. tc_o<=0.
- Terminal action (en_i=1, state RUN, terminal), tc_o<=1, then per mode:
  - WRAP: up -> 0; down -> limit_i.
  - SAT: hold count. tc_o stays high on every enabled cycle while held. Flipping up_i resumes counting.
  - RELOAD: count<=reload_q.
  - ONESHOT: hold count, state<=DONE, done_o<=1.
- en_i=0: count held, tc_o<=0.
- DONE state: count held, tc_o=0, done_o=1. Exit to RUN on load_i, or on the first edge where mode_i!=ONESHOT. In the second case done_o<=0 and no step is taken on that edge.
- mode_i, up_i and limit_i are sampled every edge; a change takes effect on the same edge it is seen.
- limit_i=0, up, WRAP: count stays 0 and tc_o is high every enabled cycle.
- Arithmetic is modulo 2^WIDTH internally. The terminal check guarantees the step never overflows in the up direction.
- State machine: RUN, DONE (2 states, 1 flop).

Optional Feature:
Macro RELOAD_COUNTER_STICKY_OVF_EN.
- Defined: adds port ovf_clr_i (input, 1) and port ovf_o (output, 1).
  - ovf_o is a sticky flag. It sets on any edge where a terminal action occurs and clears on ovf_clr_i.
  - Set wins over a simultaneous clear. Reset clears it; load_i does not affect it.
- Undefined: both ports and the flop are absent; all other behaviour is unchanged.

Decomposition:
- Package reload_counter_pkg: enum cnt_mode_e (CNT_WRAP=2'b00, CNT_SAT=2'b01, CNT_RELOAD=2'b10, CNT_ONESHOT=2'b11) and enum cnt_state_e (ST_RUN, ST_DONE).
- Sub-module counter_next_val: purely combinational. Takes count, up, mode, limit and reload_q; returns next count and a terminal flag. Keeps the sequential top small and makes the step logic unit-testable.

Test Plan:
1. WIDTH=4, reset, limit_i=15, up, WRAP, en held -> count_o 0..15 then 0; tc_o=1 only in the cycle count_o shows 0.
2. load_i with load_val_i=9, RELOAD, limit_i=12, up, en -> 9,10,11,12,9,10; tc_o=1 with the second 9; reload_q survives the wrap.
3. Load 2, down, SAT, en -> 2,1,0,0,0; tc_o=1 from the cycle after 0 first appears and stays high. Then up_i=1 -> 1, tc_o=0.
4. ONESHOT, limit_i=3, up, from 0 -> 0,1,2,3,3; done_o=1 and tc_o=1 one cycle. Count then holds 3 with en high. load_i value 1 -> count_o=1, done_o=0, counting resumes.
5. Priority: reset and load_i (val 7) together -> count_o=RST_VAL. load_i (val 5) and en_i at terminal together -> count_o=5, tc_o=0. Reset mid-DONE -> RUN, count_o=RST_VAL, done_o=0.
6. With RELOAD_COUNTER_STICKY_OVF_EN: WRAP limit 2 wraps -> ovf_o=1 and stays. ovf_clr_i on a non-terminal cycle -> 0. ovf_clr_i on a terminal cycle -> stays 1.
